// File: rtl/alu_arbiter_pkg.sv
// Shared widths, operand-source encodings, ALU op codes and arbiter FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arbiter_pkg;

  localparam int CPU_WIDTH     = 32;
  localparam int ALU_SRC_WIDTH = 2;
  localparam int ALU_OP_WIDTH  = 4;

  // Operand mux source selects: which pair feeds the ALU A/B inputs.
  localparam logic [ALU_SRC_WIDTH-1:0] ALU_SRC_REG     = 2'd0; // reg1, reg2
  localparam logic [ALU_SRC_WIDTH-1:0] ALU_SRC_IMM     = 2'd1; // reg1, imm
  localparam logic [ALU_SRC_WIDTH-1:0] ALU_SRC_FOUR_PC = 2'd2; // pc, 4
  localparam logic [ALU_SRC_WIDTH-1:0] ALU_SRC_IMM_PC  = 2'd3; // pc, imm

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR = 4'd4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arb_grant.sv
// Combinational two-way grant: fixed priority (req 0 wins), or round-robin with ALU_ARB_RR_EN.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller qualifies the grant with its own accept condition.
module alu_arb_grant (
  input  logic [1:0] valid,
`ifdef ALU_ARB_RR_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

  // One-hot grant; on contention pick the requester that did not win last time (RR) or requester 0.
  always_comb begin
    grant = 2'b00;
`ifdef ALU_ARB_RR_EN
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
`else
    if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one operand-mux+ALU between two requesters; ALU_ARB_RR_EN selects round-robin over fixed priority.
// Latency: accept at edge T, operands drive the ALU in T+1, rsp_valid from T+2 (3-cycle minimum service).
// Backpressure: result held while rsp_ready is low; no new request is accepted until the response drains.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DW = CPU_WIDTH,
  parameter int SW = ALU_SRC_WIDTH,
  parameter int OW = ALU_OP_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [SW-1:0] req0_src_sel,
  input  logic [OW-1:0] req0_op,
  input  logic [DW-1:0] req0_reg1,
  input  logic [DW-1:0] req0_reg2,
  input  logic [DW-1:0] req0_imm,
  input  logic [DW-1:0] req0_pc,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [SW-1:0] req1_src_sel,
  input  logic [OW-1:0] req1_op,
  input  logic [DW-1:0] req1_reg1,
  input  logic [DW-1:0] req1_reg2,
  input  logic [DW-1:0] req1_imm,
  input  logic [DW-1:0] req1_pc,
  output logic [SW-1:0] alu_src_sel,
  output logic [OW-1:0] alu_op,
  output logic [DW-1:0] reg1_rdata,
  output logic [DW-1:0] reg2_rdata,
  output logic [DW-1:0] imm,
  output logic [DW-1:0] curr_pc,
  input  logic [DW-1:0] alu_res,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data
);

  arb_state_t    state_q, state_d;
  logic [1:0]    grant;
  logic          accept;

  logic [SW-1:0] src_sel_q;
  logic [OW-1:0] op_q;
  logic [DW-1:0] reg1_q, reg2_q, imm_q, pc_q;
  logic          owner_q;

  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic [DW-1:0] rsp_data_q;

`ifdef ALU_ARB_RR_EN
  logic          last_grant_q;

  alu_arb_grant u_grant (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Remember the most recent winner; reset to 1 so requester 0 wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= grant[1];
    end
  end
`else
  alu_arb_grant u_grant (
    .valid (({req1_valid, req0_valid})),
    .grant (grant)
  );
`endif

  // A request is taken only from IDLE, so rsp_ready never reaches the readys combinationally.
  assign accept = (state_q == ARB_IDLE) && (grant != 2'b00);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and request readys; readys are only ever raised in IDLE.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        if (grant != 2'b00) begin
          state_d = ARB_EXEC;
        end
      end
      ARB_EXEC: state_d = ARB_RESP;
      ARB_RESP: begin
        if (rsp_ready) begin
          state_d = ARB_IDLE;
        end
      end
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Operand registers: latch the winner's fields on accept, hold them otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_sel_q <= SW'(ALU_SRC_REG);
      op_q      <= '0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      owner_q   <= 1'b0;
    end else if (accept) begin
      owner_q   <= grant[1];
      src_sel_q <= grant[1] ? req1_src_sel : req0_src_sel;
      op_q      <= grant[1] ? req1_op      : req0_op;
      reg1_q    <= grant[1] ? req1_reg1    : req0_reg1;
      reg2_q    <= grant[1] ? req1_reg2    : req0_reg2;
      imm_q     <= grant[1] ? req1_imm     : req0_imm;
      pc_q      <= grant[1] ? req1_pc      : req0_pc;
    end
  end

  // Result register: sole capture point of the mux+ALU path; held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else if (state_q == ARB_EXEC) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= owner_q;
      rsp_data_q  <= alu_res;
    end else if ((state_q == ARB_RESP) && rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign alu_src_sel = src_sel_q;
  assign alu_op      = op_q;
  assign reg1_rdata  = reg1_q;
  assign reg2_rdata  = reg2_q;
  assign imm         = imm_q;
  assign curr_pc     = pc_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised self-checking bench for alu_arbiter with a behavioural ALU and arbitration model.
// Latency: checks accept -> EXEC -> RESP timing and the 3-cycle service interval.
// Backpressure: stalls rsp_ready and checks the response and readys stay frozen.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1;
  logic        req0_ready, req1_ready;
  logic [1:0]  f_src [2];
  logic [3:0]  f_op  [2];
  logic [31:0] f_r1  [2];
  logic [31:0] f_r2  [2];
  logic [31:0] f_imm [2];
  logic [31:0] f_pc  [2];
  logic [1:0]  alu_src_sel;
  logic [3:0]  alu_op;
  logic [31:0] reg1_rdata, reg2_rdata, imm, curr_pc, alu_res, rsp_data;
  logic        rsp_valid, rsp_ready, rsp_id;

  int total = 0;
  int bad   = 0;
  int exp_last = 1;

  // Observations gathered by run_txn
  logic [1:0]  obs_exec_src;
  logic [3:0]  obs_exec_op;
  logic [31:0] obs_exec_pc;
  logic        obs_exec_rdy, obs_exec_vld;
  logic        obs_vld, obs_id, obs_stable, obs_after_vld;
  logic [31:0] obs_data;

  always #5 clk = ~clk;

  // Behavioural ALU: operand selection and arithmetic from the encoding table.
  function automatic logic [31:0] alu_ref(input logic [1:0] s, input logic [3:0] o,
                                          input logic [31:0] r1, r2, im, pc);
    logic [31:0] a, b;
    case (s)
      ALU_SRC_REG:     begin a = r1; b = r2;    end
      ALU_SRC_IMM:     begin a = r1; b = im;    end
      ALU_SRC_FOUR_PC: begin a = pc; b = 32'd4; end
      default:         begin a = pc; b = im;    end
    endcase
    case (o)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      ALU_OP_XOR: return a ^ b;
      default:    return 32'd0;
    endcase
  endfunction

  assign alu_res = alu_ref(alu_src_sel, alu_op, reg1_rdata, reg2_rdata, imm, curr_pc);

  // Arbitration policy model: single requester served; on contention RR alternates, fixed picks 0.
  function automatic int exp_winner(input logic a0, input logic a1);
    if (a0 && a1) begin
`ifdef ALU_ARB_RR_EN
      return (exp_last == 1) ? 0 : 1;
`else
      return 0;
`endif
    end
    return a1 ? 1 : 0;
  endfunction

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_src_sel(f_src[0]), .req0_op(f_op[0]),
    .req0_reg1(f_r1[0]), .req0_reg2(f_r2[0]), .req0_imm(f_imm[0]), .req0_pc(f_pc[0]),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_src_sel(f_src[1]), .req1_op(f_op[1]),
    .req1_reg1(f_r1[1]), .req1_reg2(f_r2[1]), .req1_imm(f_imm[1]), .req1_pc(f_pc[1]),
    .alu_src_sel(alu_src_sel), .alu_op(alu_op), .reg1_rdata(reg1_rdata), .reg2_rdata(reg2_rdata),
    .imm(imm), .curr_pc(curr_pc), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  task automatic set_fields(input int n, input logic [1:0] s, input logic [3:0] o,
                            input logic [31:0] r1, r2, im, pc);
    f_src[n] = s; f_op[n] = o; f_r1[n] = r1; f_r2[n] = r2; f_imm[n] = im; f_pc[n] = pc;
  endtask

  // Drives one request through accept/EXEC/RESP, recording observations; called right after a negedge.
  task automatic run_txn(input bit keep, input int hold, output int win, output int waited, output bit to);
    to = 1'b0; win = -1; waited = 0;
    #1;
    while (!(req0_ready || req1_ready)) begin
      if (waited >= 20) begin
        to = 1'b1;
        return;
      end
      @(negedge clk); #1;
      waited++;
    end
    win = (req0_ready && req1_ready) ? 2 : (req1_ready ? 1 : 0);
    rsp_ready = 1'b0;
    @(negedge clk);
    obs_exec_src = alu_src_sel;
    obs_exec_op  = alu_op;
    obs_exec_pc  = curr_pc;
    obs_exec_rdy = req0_ready | req1_ready;
    obs_exec_vld = rsp_valid;
    if (!keep) begin v0 = 1'b0; v1 = 1'b0; end
    rsp_ready = (hold == 0);
    @(negedge clk);
    obs_vld = rsp_valid; obs_data = rsp_data; obs_id = rsp_id; obs_stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      if (rsp_data !== obs_data || rsp_id !== obs_id || rsp_valid !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) obs_stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    obs_after_vld = rsp_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
    set_fields(0, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    set_fields(1, 2'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0; exp_last = 1;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {req0_ready, req1_ready, rsp_valid, rsp_id});
    end
    total++;
    if (rsp_data !== 32'd0 || alu_op !== 4'd0 || alu_src_sel !== ALU_SRC_REG) begin
      bad++; $display("FAIL reset_data got data=%h op=%h src=%h want 0/0/%h", rsp_data, alu_op, alu_src_sel, ALU_SRC_REG);
    end
    total++;
    if ((reg1_rdata | reg2_rdata | imm | curr_pc) !== 32'd0) begin
      bad++; $display("FAIL reset_operands got=%h %h %h %h want=0", reg1_rdata, reg2_rdata, imm, curr_pc);
    end
  endtask

  task automatic test_single;
    int w, wt; bit to;
    set_fields(0, ALU_SRC_IMM, ALU_OP_ADD, 32'd5, 32'd99, 32'd7, 32'h40);
    v0 = 1'b1;
    run_txn(1'b0, 0, w, wt, to);
    total++;
    if (to || w !== 0 || wt !== 0) begin
      bad++; $display("FAIL single_accept got win=%0d wait=%0d to=%0d want 0/0/0", w, wt, to);
    end
    exp_last = 0;
    total++;
    if (obs_exec_src !== ALU_SRC_IMM || obs_exec_vld !== 1'b0 || obs_exec_rdy !== 1'b0) begin
      bad++; $display("FAIL single_exec got src=%h vld=%b rdy=%b want %h/0/0", obs_exec_src, obs_exec_vld, obs_exec_rdy, ALU_SRC_IMM);
    end
    total++;
    if (obs_vld !== 1'b1 || obs_data !== 32'd12 || obs_id !== 1'b0) begin
      bad++; $display("FAIL single_rsp got vld=%b data=%0d id=%b want 1/12/0", obs_vld, obs_data, obs_id);
    end
    total++;
    if (obs_after_vld !== 1'b0) begin
      bad++; $display("FAIL single_drain got rsp_valid=%b want 0", obs_after_vld);
    end
  endtask

  task automatic test_pc4;
    int w, wt; bit to;
    set_fields(1, ALU_SRC_FOUR_PC, ALU_OP_ADD, 32'd1, 32'd2, 32'd3, 32'h100);
    v1 = 1'b1;
    run_txn(1'b0, 0, w, wt, to);
    total++;
    if (to || w !== 1) begin
      bad++; $display("FAIL pc4_accept got win=%0d to=%0d want 1/0", w, to);
    end
    exp_last = 1;
    total++;
    if (obs_exec_pc !== 32'h100 || obs_exec_src !== ALU_SRC_FOUR_PC) begin
      bad++; $display("FAIL pc4_exec got pc=%h src=%h want 100/%h", obs_exec_pc, obs_exec_src, ALU_SRC_FOUR_PC);
    end
    total++;
    if (obs_data !== 32'h104 || obs_id !== 1'b1 || obs_vld !== 1'b1) begin
      bad++; $display("FAIL pc4_rsp got data=%h id=%b vld=%b want 104/1/1", obs_data, obs_id, obs_vld);
    end
  endtask

  task automatic test_contention;
    int w, wt; bit to; int ew;
    set_fields(0, ALU_SRC_REG, ALU_OP_SUB, 32'd50, 32'd8, 32'd0, 32'd0);
    set_fields(1, ALU_SRC_IMM_PC, ALU_OP_ADD, 32'd0, 32'd0, 32'h20, 32'h300);
    v0 = 1'b1; v1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ew = exp_winner(1'b1, 1'b1);
      run_txn(1'b1, 0, w, wt, to);
      total++;
      if (to || w !== ew || (k > 0 && wt !== 0)) begin
        bad++; $display("FAIL contention_%0d got win=%0d wait=%0d to=%0d want win=%0d wait=0", k, w, wt, to, ew);
      end
      total++;
      if (obs_data !== (ew == 0 ? 32'd42 : 32'h320) || obs_id !== ew[0]) begin
        bad++; $display("FAIL contention_rsp_%0d got data=%h id=%b", k, obs_data, obs_id);
      end
      exp_last = ew;
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_backpressure;
    int w, wt; bit to;
    set_fields(0, ALU_SRC_REG, ALU_OP_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0);
    v0 = 1'b1;
    run_txn(1'b1, 4, w, wt, to);
    exp_last = 0;
    total++;
    if (to || obs_stable !== 1'b1 || obs_data !== 32'hFF00 || obs_id !== 1'b0) begin
      bad++; $display("FAIL bp_hold got stable=%b data=%h id=%b to=%0d want 1/ff00/0/0", obs_stable, obs_data, obs_id, to);
    end
    v0 = 1'b0;
    set_fields(1, ALU_SRC_REG, ALU_OP_OR, 32'h1, 32'h2, 32'd0, 32'd0);
    v1 = 1'b1;
    run_txn(1'b0, 0, w, wt, to);
    total++;
    if (to || w !== 1 || wt !== 0 || obs_data !== 32'h3) begin
      bad++; $display("FAIL bp_next got win=%0d wait=%0d data=%h want 1/0/3", w, wt, obs_data);
    end
    exp_last = 1;
  endtask

  task automatic test_reset_mid_exec;
    int w, wt; bit to;
    set_fields(0, ALU_SRC_REG, ALU_OP_ADD, 32'd3, 32'd4, 32'd0, 32'd0);
    v0 = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b1; v0 = 1'b0;
    @(negedge clk);
    rst = 1'b0; exp_last = 1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
      bad++; $display("FAIL rst_exec_rsp got vld=%b data=%h want 0/0", rsp_valid, rsp_data);
    end
    @(negedge clk);
    set_fields(1, ALU_SRC_REG, ALU_OP_AND, 32'hFF, 32'h0F, 32'd0, 32'd0);
    v1 = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      bad++; $display("FAIL rst_exec_idle got vld=%b req1_ready=%b want 0/1", rsp_valid, req1_ready);
    end
    run_txn(1'b0, 0, w, wt, to);
    total++;
    if (to || w !== 1 || obs_data !== 32'h0F || obs_id !== 1'b1) begin
      bad++; $display("FAIL rst_exec_next got win=%0d data=%h id=%b want 1/f/1", w, obs_data, obs_id);
    end
    exp_last = 1;
  endtask

  task automatic test_random;
    int w, wt, ew, hold; bit to; logic a0, a1; logic [31:0] ed;
    for (int k = 0; k < 40; k++) begin
      for (int n = 0; n < 2; n++)
        set_fields(n, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 5)),
                   $urandom, $urandom, $urandom, $urandom);
      a0 = 1'($urandom_range(0, 1)); a1 = 1'($urandom_range(0, 1));
      if (!a0 && !a1) a0 = 1'b1;
      hold = $urandom_range(0, 3);
      ew = exp_winner(a0, a1);
      ed = alu_ref(f_src[ew], f_op[ew], f_r1[ew], f_r2[ew], f_imm[ew], f_pc[ew]);
      v0 = a0; v1 = a1;
      run_txn(1'b0, hold, w, wt, to);
      total++;
      if (to || w !== ew || wt !== 0 || obs_data !== ed || obs_id !== ew[0] ||
          obs_vld !== 1'b1 || obs_stable !== 1'b1 || obs_after_vld !== 1'b0) begin
        bad++;
        $display("FAIL random_%0d got win=%0d data=%h id=%b stable=%b to=%0d want win=%0d data=%h",
                 k, w, obs_data, obs_id, obs_stable, to, ew, ed);
      end
      exp_last = ew;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pc4();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
